wav_stream_sequencer: RTL and testbench

- Hardware WAV stream generator for the audio path.
- On start, emits a 44-byte canonical PCM WAV header as a byte stream, then little-endian PCM sample bytes pulled from an upstream sample source.
- Also generates the sample-rate strobe (fs_tick) that paces the upstream ADC/DSP.
- Sits between the audio sample producer and a byte sink (UART/FIFO/file-capture port); the stream it emits is byte-identical to the WAV files the bench writes.

---
 rtl/wav_stream_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_wav_stream_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wav_stream_sequencer.sv
// WAV stream generator: 44-byte canonical PCM header followed by little-endian
// sample bytes pulled from an upstream source, plus the fs_tick sample strobe.
module wav_stream_sequencer #(
    parameter int CLK_HZ        = 50000000,
    parameter int FS            = 12500,
    parameter int BITS_PER_SAMP = 16,
    parameter int CHANNELS      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] num_samples,
    output logic        fs_tick,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam int          BYTES       = BITS_PER_SAMP / 8;
    localparam int          DIV         = CLK_HZ / FS;
    localparam logic [31:0] DIV_M1      = 32'(DIV - 1);
    localparam logic [31:0] FS_W        = 32'(FS);
    localparam logic [31:0] BYTE_RATE   = 32'(FS * CHANNELS * BYTES);
    localparam logic [15:0] CH_W        = 16'(CHANNELS);
    localparam logic [15:0] BLOCK_ALIGN = 16'(CHANNELS * BYTES);
    localparam logic [15:0] BPS_W       = 16'(BITS_PER_SAMP);

    if (BITS_PER_SAMP != 8 && BITS_PER_SAMP != 16) begin : g_bad_bits
        $error("wav_stream_sequencer: BITS_PER_SAMP must be 8 or 16");
    end
    if (DIV < 1) begin : g_bad_div
        $error("wav_stream_sequencer: CLK_HZ/FS must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, HDR, FETCH, B0, B1, FIN} state_t;

    state_t       state, state_nx;
    logic [5:0]   idx, idx_nx;
    logic [31:0]  nsamp, nsamp_nx;
    logic [31:0]  cnt, cnt_nx;
    logic [15:0]  sample, sample_nx;
    logic         last_s, last_nx;
    logic         m_valid_nx, m_last_nx, busy_nx, done_nx;
    logic [7:0]   m_data_nx;
    logic [31:0]  tcnt, tcnt_nx;
    logic [31:0]  data_size;
    logic [43:0][7:0] hdr;
    logic         xfer;

    assign xfer      = m_valid && m_ready;
    assign s_ready   = (state == FETCH);
    assign data_size = (BYTES == 2) ? {nsamp[30:0], 1'b0} : nsamp;

    // Packed slices put the low byte at the lower index, so multi-byte fields
    // land little-endian; ASCII tags are written reversed for the same reason.
    always_comb begin
        hdr         = '0;
        hdr[3:0]    = "FFIR";
        hdr[7:4]    = data_size + 32'd36;
        hdr[15:8]   = " tmfEVAW";
        hdr[19:16]  = 32'd16;
        hdr[21:20]  = 16'd1;
        hdr[23:22]  = CH_W;
        hdr[27:24]  = FS_W;
        hdr[31:28]  = BYTE_RATE;
        hdr[33:32]  = BLOCK_ALIGN;
        hdr[35:34]  = BPS_W;
        hdr[39:36]  = "atad";
        hdr[43:40]  = data_size;
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        nsamp_nx   = nsamp;
        cnt_nx     = cnt;
        sample_nx  = sample;
        last_nx    = last_s;
        m_valid_nx = m_valid;
        m_data_nx  = m_data;
        m_last_nx  = m_last;
        busy_nx    = busy;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = HDR;
                    idx_nx     = '0;
                    nsamp_nx   = num_samples;
                    cnt_nx     = '0;
                    busy_nx    = 1'b1;
                    m_valid_nx = 1'b1;
                    m_data_nx  = hdr[0];
                    m_last_nx  = 1'b0;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (idx == 6'd43) begin
                        m_valid_nx = 1'b0;
                        m_last_nx  = 1'b0;
                        if (nsamp == '0) begin
                            state_nx = FIN;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = FETCH;
                        end
                    end else begin
                        idx_nx    = idx + 6'd1;
                        m_data_nx = hdr[idx_nx];
                        m_last_nx = (idx_nx == 6'd43) && (nsamp == '0);
                    end
                end
            end
            FETCH: begin
                if (s_valid) begin
                    sample_nx  = s_data;
                    last_nx    = (cnt + 32'd1 == nsamp);
                    cnt_nx     = cnt + 32'd1;
                    state_nx   = B0;
                    m_valid_nx = 1'b1;
                    m_data_nx  = s_data[7:0];
                    m_last_nx  = (BYTES == 1) && last_nx;
                end
            end
            B0, B1: begin
                if (xfer) begin
                    if (state == B0 && BYTES == 2) begin
                        state_nx  = B1;
                        m_data_nx = sample[15:8];
                        m_last_nx = last_s;
                    end else begin
                        m_valid_nx = 1'b0;
                        m_last_nx  = 1'b0;
                        if (last_s) begin
                            state_nx = FIN;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = FETCH;
                        end
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            nsamp   <= '0;
            cnt     <= '0;
            sample  <= '0;
            last_s  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            nsamp   <= nsamp_nx;
            cnt     <= cnt_nx;
            sample  <= sample_nx;
            last_s  <= last_nx;
            m_valid <= m_valid_nx;
            m_data  <= m_data_nx;
            m_last  <= m_last_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    // Sample-rate divider; realigned to the stream on every accepted start.
    always_comb begin
        if (state == IDLE && start) tcnt_nx = '0;
        else if (tcnt == DIV_M1)    tcnt_nx = '0;
        else                        tcnt_nx = tcnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt    <= '0;
            fs_tick <= 1'b0;
        end else begin
            tcnt    <= tcnt_nx;
            fs_tick <= (tcnt_nx == DIV_M1);
        end
    end

endmodule

// File: tb/tb_wav_stream_sequencer.sv
// Scoreboard bench for wav_stream_sequencer: a 16-bit and an 8-bit build driven
// with directed streams; expected bytes are queued up front and popped by monitors.
module tb_wav_stream_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        m_ready = 1'b1;
    logic        start16 = 1'b0, start8 = 1'b0;
    logic [31:0] n16 = '0, n8 = '0;
    logic        sv16 = 1'b0, sv8 = 1'b0;
    logic [15:0] sd16 = '0, sd8 = '0;
    logic        tick16, sr16, mv16, ml16, busy16, done16;
    logic        tick8, sr8, mv8, ml8, busy8, done8;
    logic [7:0]  md16, md8;

    wav_stream_sequencer #(.CLK_HZ(100000), .FS(12500), .BITS_PER_SAMP(16), .CHANNELS(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .num_samples(n16), .fs_tick(tick16),
        .s_valid(sv16), .s_ready(sr16), .s_data(sd16), .m_valid(mv16), .m_ready(m_ready),
        .m_data(md16), .m_last(ml16), .busy(busy16), .done(done16));

    wav_stream_sequencer #(.CLK_HZ(100000), .FS(12500), .BITS_PER_SAMP(8), .CHANNELS(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .num_samples(n8), .fs_tick(tick8),
        .s_valid(sv8), .s_ready(sr8), .s_data(sd8), .m_valid(mv8), .m_ready(m_ready),
        .m_data(md8), .m_last(ml8), .busy(busy8), .done(done8));

    typedef struct packed {logic l; logic [7:0] d;} ent_t;

    int   total = 0, bad = 0;
    bit   bp = 1'b0;
    ent_t q16[$], q8[$];
    int   nb16 = 0, nb8 = 0, dn16 = 0, dn8 = 0, sr_seen16 = 0;
    bit   stall16 = 1'b0;
    logic [7:0] pd16 = '0;
    logic pl16 = 1'b0;

    // Header of the 16-bit, 4-sample stream; other cases patch a few bytes.
    logic [7:0] hdr_t [44] = '{
        8'h52, 8'h49, 8'h46, 8'h46, 8'h2C, 8'h00, 8'h00, 8'h00,
        8'h57, 8'h41, 8'h56, 8'h45, 8'h66, 8'h6D, 8'h74, 8'h20,
        8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
        8'hD4, 8'h30, 8'h00, 8'h00, 8'hA8, 8'h61, 8'h00, 8'h00,
        8'h02, 8'h00, 8'h10, 8'h00, 8'h64, 8'h61, 8'h74, 8'h61,
        8'h08, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input bit sel, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        if (sel) q8.push_back(e);
        else     q16.push_back(e);
    endtask

    task automatic push_hdr(input bit sel, input logic [7:0] fsz, input logic [7:0] br0,
                            input logic [7:0] br1, input logic [7:0] ba, input logic [7:0] bps,
                            input logic [7:0] dsz, input logic last43);
        logic [7:0] b;
        for (int i = 0; i < 44; i++) begin
            b = hdr_t[i];
            case (i)
                4:  b = fsz;
                28: b = br0;
                29: b = br1;
                32: b = ba;
                34: b = bps;
                40: b = dsz;
                default: ;
            endcase
            push_byte(sel, b, (i == 43) && last43);
        end
    endtask

    // m_ready changes just after the rising edge so monitors see it settled.
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stall16 = 1'b0;
        end else begin
            if (stall16) begin
                chk("stall_valid16", 32'(mv16), 32'd1);
                chk("stall_data16", 32'(md16), 32'(pd16));
                chk("stall_last16", 32'(ml16), 32'(pl16));
            end
            if (mv16 && m_ready) begin
                if (q16.size() == 0) chk("extra_byte16", 32'(q16.size()), 32'd1);
                else begin
                    ent_t e;
                    e = q16.pop_front();
                    chk($sformatf("byte16[%0d]", nb16), 32'({ml16, md16}), 32'({e.l, e.d}));
                end
                nb16++;
            end
            if (done16) dn16++;
            if (sr16) begin
                sr_seen16++;
                chk("sready_fetch16", 32'({busy16, mv16}), 32'd2);
            end
            stall16 = mv16 && !m_ready;
            pd16 = md16;
            pl16 = ml16;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mv8 && m_ready) begin
                if (q8.size() == 0) chk("extra_byte8", 32'(q8.size()), 32'd1);
                else begin
                    ent_t e;
                    e = q8.pop_front();
                    chk($sformatf("byte8[%0d]", nb8), 32'({ml8, md8}), 32'({e.l, e.d}));
                end
                nb8++;
            end
            if (done8) dn8++;
            if (sr8) chk("sready_fetch8", 32'({busy8, mv8}), 32'd2);
        end
    end

    task automatic clr();
        @(negedge clk);
        #1;
        nb16 = 0; nb8 = 0; dn16 = 0; dn8 = 0; sr_seen16 = 0;
    endtask

    // Returns on the negedge right after the start edge (cycle 0 of the stream).
    task automatic go(input bit sel, input logic [31:0] n);
        @(negedge clk);
        if (sel) begin start8 = 1'b1; n8 = n; end
        else     begin start16 = 1'b1; n16 = n; end
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic feed(input bit sel, input logic [15:0] v);
        int g;
        g = 0;
        if (sel) begin sv8 = 1'b1; sd8 = v; end
        else     begin sv16 = 1'b1; sd16 = v; end
        @(negedge clk);
        while (!(sel ? sr8 : sr16) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("feed_timeout", 32'(g), 32'd0);
        @(posedge clk);
        #1;
        sv8 = 1'b0;
        sv16 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int g;
        g = 0;
        while ((sel ? dn8 : dn16) < 1 && g < 5000) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 5000) chk("done_timeout", 32'(g), 32'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic tick_chk();
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("fs_tick[%0d]", k), 32'(tick16), 32'((k % 8) == 7));
            @(negedge clk);
        end
    endtask

    task automatic chk_idle16(input string tag);
        chk({tag, "_ctl16"}, 32'({tick16, sr16, mv16, ml16, busy16, done16}), 32'd0);
        chk({tag, "_data16"}, 32'(md16), 32'd0);
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk_idle16("reset");
        chk("reset_ctl8", 32'({tick8, sr8, mv8, ml8, busy8, done8, md8}), 32'd0);
        rst_n = 1'b1;

        // Header, data, fs_tick and start-while-busy
        clr();
        push_hdr(0, 8'h2C, 8'hA8, 8'h61, 8'h02, 8'h10, 8'h08, 1'b0);
        push_byte(0, 8'h34, 0); push_byte(0, 8'h12, 0); push_byte(0, 8'hFF, 0); push_byte(0, 8'hFF, 0);
        push_byte(0, 8'h00, 0); push_byte(0, 8'h80, 0); push_byte(0, 8'h01, 0); push_byte(0, 8'h00, 1);
        go(0, 32'd4);
        chk("busy_after_start", 32'(busy16), 32'd1);
        fork
            tick_chk();
            begin
                repeat (10) @(negedge clk);
                start16 = 1'b1; n16 = 32'd99;
                @(negedge clk);
                start16 = 1'b0;
            end
            begin
                feed(0, 16'h1234); feed(0, 16'hFFFF); feed(0, 16'h8000); feed(0, 16'h0001);
            end
        join
        wait_done(0);
        chk("t1_bytes", 32'(nb16), 32'd52);
        chk("t1_done", 32'(dn16), 32'd1);
        chk("t1_left", 32'(q16.size()), 32'd0);
        chk("t1_busy", 32'(busy16), 32'd0);

        // Same stream under random backpressure
        clr();
        bp = 1'b1;
        push_hdr(0, 8'h2C, 8'hA8, 8'h61, 8'h02, 8'h10, 8'h08, 1'b0);
        push_byte(0, 8'h34, 0); push_byte(0, 8'h12, 0); push_byte(0, 8'hFF, 0); push_byte(0, 8'hFF, 0);
        push_byte(0, 8'h00, 0); push_byte(0, 8'h80, 0); push_byte(0, 8'h01, 0); push_byte(0, 8'h00, 1);
        go(0, 32'd4);
        feed(0, 16'h1234); feed(0, 16'hFFFF); feed(0, 16'h8000); feed(0, 16'h0001);
        wait_done(0);
        bp = 1'b0;
        chk("t2_bytes", 32'(nb16), 32'd52);
        chk("t2_done", 32'(dn16), 32'd1);
        chk("t2_left", 32'(q16.size()), 32'd0);

        // Zero samples: header only, m_last on byte 43
        clr();
        push_hdr(0, 8'h24, 8'hA8, 8'h61, 8'h02, 8'h10, 8'h00, 1'b1);
        go(0, 32'd0);
        wait_done(0);
        chk("t3_bytes", 32'(nb16), 32'd44);
        chk("t3_done", 32'(dn16), 32'd1);
        chk("t3_sready", 32'(sr_seen16), 32'd0);
        chk("t3_left", 32'(q16.size()), 32'd0);

        // 8-bit build, upper sample bits carry junk
        clr();
        push_hdr(1, 8'h27, 8'hD4, 8'h30, 8'h01, 8'h08, 8'h03, 1'b0);
        push_byte(1, 8'h80, 0); push_byte(1, 8'h7F, 0); push_byte(1, 8'h00, 1);
        go(1, 32'd3);
        feed(1, 16'hAA80); feed(1, 16'h557F); feed(1, 16'hFF00);
        wait_done(1);
        chk("t4_bytes", 32'(nb8), 32'd47);
        chk("t4_done", 32'(dn8), 32'd1);
        chk("t4_left", 32'(q8.size()), 32'd0);

        // Reset while byte 20 is on the bus, then a clean restart
        clr();
        push_hdr(0, 8'h2C, 8'hA8, 8'h61, 8'h02, 8'h10, 8'h08, 1'b0);
        go(0, 32'd4);
        g = 0;
        while (nb16 < 21 && g < 500) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("t5_reach_byte20", 32'(nb16), 32'd21);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_idle16("midreset");
        q16.delete();
        rst_n = 1'b1;
        clr();
        push_hdr(0, 8'h28, 8'hA8, 8'h61, 8'h02, 8'h10, 8'h04, 1'b0);
        push_byte(0, 8'h5A, 0); push_byte(0, 8'hA5, 0); push_byte(0, 8'hFF, 0); push_byte(0, 8'h00, 1);
        go(0, 32'd2);
        feed(0, 16'hA55A); feed(0, 16'h00FF);
        wait_done(0);
        chk("t5_bytes", 32'(nb16), 32'd48);
        chk("t5_done", 32'(dn16), 32'd1);
        chk("t5_left", 32'(q16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
